// File: rtl/alu_issue_unit_if.sv
// alu_issue_unit_if
//   Bundles the three buses that connect the ALU issue unit to the rest of
//   the pipeline:
//     - instruction side : instrValid/instrReady handshake, instruction, rs1Data, rs2Data
//     - ALU side         : aluOperation, aluOperand1, aluOperand2 out; aluResult in
//     - writeback side   : resultValid/resultReady handshake, resultData, rd,
//                          branchTaken, illegal
//   slave  : the issue unit's view
//   master : the surrounding pipeline (decode, ALU, writeback) view
interface alu_issue_unit_if;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instruction;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [3:0]  aluOperation;
  logic [31:0] aluOperand1;
  logic [31:0] aluOperand2;
  logic [31:0] aluResult;
  logic        resultValid;
  logic        resultReady;
  logic [31:0] resultData;
  logic [4:0]  rd;
  logic        branchTaken;
  logic        illegal;

  modport slave (
    input  instrValid, instruction, rs1Data, rs2Data, aluResult, resultReady,
    output instrReady, aluOperation, aluOperand1, aluOperand2,
           resultValid, resultData, rd, branchTaken, illegal
  );

  modport master (
    output instrValid, instruction, rs1Data, rs2Data, aluResult, resultReady,
    input  instrReady, aluOperation, aluOperand1, aluOperand2,
           resultValid, resultData, rd, branchTaken, illegal
  );
endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Accepts one RV32 instruction plus register operands, translates it into a
//   4-bit ALU operation, drives the ALU for one execute cycle, captures the
//   result and hands it (with a branch decision) to writeback.
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-low reset
//     bus   : alu_issue_unit_if.slave (instruction, ALU and writeback buses)
//   Illegal encodings and divide-by-zero skip the execute cycle and go
//   straight to the result state with a fixed result.
module alu_issue_unit (
  input  logic             clk,
  input  logic             reset,
  alu_issue_unit_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_IDLE = 4'b1111;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;

  // instruction fields
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic        unused_fields_s;

  // decode results for the instruction currently presented
  logic [3:0]  dec_op_s;
  logic [31:0] dec_opnd2_s;
  logic [4:0]  dec_rd_s;
  logic        dec_beq_s;
  logic        dec_bne_s;
  logic        dec_ill_s;
  logic        dec_dz_s;

  // instruction captured at acceptance
  logic [3:0]  op_r;
  logic [31:0] opnd1_r;
  logic [31:0] opnd2_r;
  logic [4:0]  dest_r;
  logic        beq_r;
  logic        bne_r;

  // result returned to writeback
  logic [31:0] res_data_r;
  logic [4:0]  res_rd_r;
  logic        res_br_r;
  logic        res_ill_r;

  // state-derived outputs
  logic        instr_ready_s;
  logic        result_valid_s;
  logic [3:0]  alu_op_s;
  logic [31:0] alu_opnd1_s;
  logic [31:0] alu_opnd2_s;

  assign opcode_s = bus.instruction[6:0];
  assign funct3_s = bus.instruction[14:12];
  assign funct7_s = bus.instruction[31:25];
  // rs1 field is not needed: the register value arrives on rs1Data
  assign unused_fields_s = ^bus.instruction[19:15];

  // Instruction decode: ALU op, second operand, destination and bypass cases
  always_comb begin
    dec_op_s    = OP_IDLE;
    dec_opnd2_s = bus.rs2Data;
    dec_rd_s    = bus.instruction[11:7];
    dec_beq_s   = 1'b0;
    dec_bne_s   = 1'b0;
    dec_ill_s   = 1'b0;
    dec_dz_s    = 1'b0;
    case (opcode_s)
      OPC_R: begin
        case ({funct7_s, funct3_s})
          10'b0000000_000: dec_op_s = OP_ADD;
          10'b0100000_000: dec_op_s = OP_SUB;
          10'b0000001_000: dec_op_s = OP_MUL;
          10'b0000001_100: begin
            dec_op_s = OP_DIV;
            dec_dz_s = (bus.rs2Data == 32'd0);
          end
          10'b0000000_001: dec_op_s = OP_SLL;
          10'b0100000_101: dec_op_s = OP_SRA;
          default:         dec_ill_s = 1'b1;
        endcase
      end
      OPC_I: begin
        case (funct3_s)
          3'b000: begin
            dec_op_s    = OP_ADD;
            dec_opnd2_s = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
          end
          3'b001: begin
            if (funct7_s == 7'b0000000) begin
              dec_op_s    = OP_SLL;
              dec_opnd2_s = {27'd0, bus.instruction[24:20]};
            end else begin
              dec_ill_s = 1'b1;
            end
          end
          3'b101: begin
            if (funct7_s == 7'b0100000) begin
              dec_op_s    = OP_SRA;
              dec_opnd2_s = {27'd0, bus.instruction[24:20]};
            end else begin
              dec_ill_s = 1'b1;
            end
          end
          default: dec_ill_s = 1'b1;
        endcase
      end
      OPC_BR: begin
        // branches compare via subtraction and never write a register
        dec_rd_s = 5'd0;
        case (funct3_s)
          3'b000: begin
            dec_op_s  = OP_SUB;
            dec_beq_s = 1'b1;
          end
          3'b001: begin
            dec_op_s  = OP_SUB;
            dec_bne_s = 1'b1;
          end
          default: dec_ill_s = 1'b1;
        endcase
      end
      default: dec_ill_s = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.instrValid) begin
          if (dec_ill_s || dec_dz_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_EXEC;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nx_s = ST_DONE;
      ST_DONE: begin
        if (bus.resultReady) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs: the ALU is only driven during the execute cycle
  always_comb begin
    instr_ready_s  = 1'b0;
    result_valid_s = 1'b0;
    alu_op_s       = OP_IDLE;
    alu_opnd1_s    = 32'd0;
    alu_opnd2_s    = 32'd0;
    case (state_r)
      ST_IDLE: instr_ready_s = 1'b1;
      ST_EXEC: begin
        alu_op_s    = op_r;
        alu_opnd1_s = opnd1_r;
        alu_opnd2_s = opnd2_r;
      end
      ST_DONE: result_valid_s = 1'b1;
      default: instr_ready_s = 1'b0;
    endcase
  end

  // Capture decoded instruction at acceptance so inputs may change afterwards
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_r    <= OP_IDLE;
      opnd1_r <= 32'd0;
      opnd2_r <= 32'd0;
      dest_r  <= 5'd0;
      beq_r   <= 1'b0;
      bne_r   <= 1'b0;
    end else if ((state_r == ST_IDLE) && bus.instrValid) begin
      op_r    <= dec_op_s;
      opnd1_r <= bus.rs1Data;
      opnd2_r <= dec_opnd2_s;
      dest_r  <= dec_rd_s;
      beq_r   <= dec_beq_s;
      bne_r   <= dec_bne_s;
    end else begin
      op_r    <= op_r;
      opnd1_r <= opnd1_r;
      opnd2_r <= opnd2_r;
      dest_r  <= dest_r;
      beq_r   <= beq_r;
      bne_r   <= bne_r;
    end
  end

  // Result registers: loaded on entry to DONE, cleared on handoff to writeback
  always_ff @(posedge clk) begin
    if (!reset) begin
      res_data_r <= 32'd0;
      res_rd_r   <= 5'd0;
      res_br_r   <= 1'b0;
      res_ill_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.instrValid && dec_ill_s) begin
            res_data_r <= 32'd0;
            res_rd_r   <= 5'd0;
            res_br_r   <= 1'b0;
            res_ill_r  <= 1'b1;
          end else if (bus.instrValid && dec_dz_s) begin
            res_data_r <= 32'hFFFF_FFFF;
            res_rd_r   <= dec_rd_s;
            res_br_r   <= 1'b0;
            res_ill_r  <= 1'b0;
          end else begin
            res_data_r <= res_data_r;
            res_rd_r   <= res_rd_r;
            res_br_r   <= res_br_r;
            res_ill_r  <= res_ill_r;
          end
        end
        ST_EXEC: begin
          // zero test is done locally on the sub result; no ALU flag is used
          res_data_r <= (beq_r || bne_r) ? 32'd0 : bus.aluResult;
          res_rd_r   <= dest_r;
          res_br_r   <= (beq_r && (bus.aluResult == 32'd0)) ||
                        (bne_r && (bus.aluResult != 32'd0));
          res_ill_r  <= 1'b0;
        end
        ST_DONE: begin
          if (bus.resultReady) begin
            res_data_r <= 32'd0;
            res_rd_r   <= 5'd0;
            res_br_r   <= 1'b0;
            res_ill_r  <= 1'b0;
          end else begin
            res_data_r <= res_data_r;
            res_rd_r   <= res_rd_r;
            res_br_r   <= res_br_r;
            res_ill_r  <= res_ill_r;
          end
        end
        default: begin
          res_data_r <= 32'd0;
          res_rd_r   <= 5'd0;
          res_br_r   <= 1'b0;
          res_ill_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instrReady   = instr_ready_s;
  assign bus.resultValid  = result_valid_s;
  assign bus.aluOperation = alu_op_s;
  assign bus.aluOperand1  = alu_opnd1_s;
  assign bus.aluOperand2  = alu_opnd2_s;
  assign bus.resultData   = res_data_r;
  assign bus.rd           = res_rd_r;
  assign bus.branchTaken  = res_br_r;
  assign bus.illegal      = res_ill_r;

endmodule
